// File: rtl/rpn_pkg.sv
// Shared opcode, FSM state and error-code definitions for the RPN evaluator
// and its operand stack.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_DUP  = 3'd6,
    OP_POP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP_B = 2'd1,
    S_POP_A = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

endpackage

// File: rtl/rpn_stack.sv
// DEPTH x DATA_W LIFO. The caller guarantees push/pop are exclusive and that
// it never pushes when full or pops when empty.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic [DATA_W-1:0]          top_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wrIdx, topIdx;

  assign wrIdx   = AW'(count_q);
  assign topIdx  = AW'(count_q - CW'(1));
  assign top_o   = (count_q == '0) ? '0 : mem_q[topIdx];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Emptying the stack only needs the count cleared; stale entries are unreachable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrIdx] <= push_data_i;
    end
  end

endmodule

// File: rtl/rpn_engine.sv
// Reverse-Polish evaluator: turns operand/operator tokens into push/pop
// sequences on rpn_stack and reports results and stack errors.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       res_valid,
  output logic [DATA_W-1:0]          res_data,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  op_e               opCode_q, opCode_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [DATA_W-1:0] resData_q, resData_d;
  logic              resValid_q, resValid_d;
  logic              err_q, err_d;
  logic [1:0]        errCode_q, errCode_d;

  logic              stackPush, stackPop;
  logic [DATA_W-1:0] stackWData, stackTop, aluResult;
  logic [CW-1:0]     stackCount;
  op_e               opIn;
  logic              isBinary, underflow, overflow;

  function automatic logic [DATA_W-1:0] aluOp(input op_e op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  rpn_stack #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (stackPush),
    .pop_i       (stackPop),
    .push_data_i (stackWData),
    .top_o       (stackTop),
    .count_o     (stackCount)
  );

  assign opIn      = op_e'(in_op);
  assign isBinary  = (opIn == OP_ADD) || (opIn == OP_SUB) || (opIn == OP_AND) ||
                     (opIn == OP_OR)  || (opIn == OP_XOR);
  assign underflow = (isBinary && (stackCount < CW'(2))) ||
                     (((opIn == OP_DUP) || (opIn == OP_POP)) && (stackCount == '0));
  assign overflow  = ((opIn == OP_PUSH) || (opIn == OP_DUP)) && (stackCount == CW'(DEPTH));
  assign aluResult = aluOp(opCode_q, opA_q, opB_q);

  assign in_ready  = (state_q == S_IDLE) & ~reset;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign err       = err_q;
  assign err_code  = errCode_q;
  assign depth     = stackCount;

  // Errors are checked only at acceptance; a binary op on a full stack is legal
  // because it pops twice before pushing its result.
  always_comb begin
    state_d    = state_q;
    opCode_d   = opCode_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    resData_d  = resData_q;
    resValid_d = 1'b0;
    err_d      = 1'b0;
    errCode_d  = errCode_q;
    stackPush  = 1'b0;
    stackPop   = 1'b0;
    stackWData = in_data;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          opCode_d = opIn;
          if (underflow) begin
            err_d     = 1'b1;
            errCode_d = ERR_UNDER;
          end else if (overflow) begin
            err_d     = 1'b1;
            errCode_d = ERR_OVER;
          end else begin
            case (opIn)
              OP_PUSH: stackPush = 1'b1;
              OP_POP: begin
                stackPop   = 1'b1;
                resData_d  = stackTop;
                resValid_d = 1'b1;
              end
              OP_DUP: begin
                opB_d   = stackTop;
                state_d = S_WRITE;
              end
              default: state_d = S_POP_B;
            endcase
          end
        end
      end
      S_POP_B: begin
        opB_d    = stackTop;
        stackPop = 1'b1;
        state_d  = S_POP_A;
      end
      S_POP_A: begin
        opA_d    = stackTop;
        stackPop = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        stackPush = 1'b1;
        state_d   = S_IDLE;
        if (opCode_q == OP_DUP) begin
          stackWData = opB_q;
        end else begin
          stackWData = aluResult;
          resData_d  = aluResult;
          resValid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      opCode_q   <= OP_PUSH;
      opA_q      <= '0;
      opB_q      <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      opCode_q   <= opCode_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      resData_q  <= resData_d;
      resValid_q <= resValid_d;
      err_q      <= err_d;
      errCode_q  <= errCode_d;
    end
  end

endmodule
